// File: rtl/cpu_dbus_decoder.sv
// cpu_dbus_decoder: routes CPU data-bus requests to a 32 KiB data RAM window,
// a 64 KiB peripheral window, or an error response, one transaction at a time.
// Latency: RAM 2 cycles accept-to-response, error 1 cycle, peripheral p_ack+1 or timeout.
// Backpressure: d_gnt_o is low whenever a transaction is outstanding.
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   d_addr_i/d_req_i/d_we_i/d_be_i/d_wdata_i   CPU request
//   d_gnt_o                             request accepted this cycle (combinational)
//   d_rdata_o/d_valid_o/d_err_o         registered one-cycle response
//   ram_addr_o/ram_req_o/ram_we_o/ram_be_o/ram_wdata_o   RAM port (combinational)
//   ram_rdata_i/ram_valid_i             RAM response, one cycle after ram_req_o
//   p_addr_o/p_req_o/p_we_o/p_be_o/p_wdata_o   registered peripheral request
//   p_rdata_i/p_ack_i                   peripheral response, arbitrary latency
module cpu_dbus_decoder #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        d_err_o,
  output logic [14:0] ram_addr_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_valid_i,
  output logic [15:0] p_addr_o,
  output logic        p_req_o,
  output logic        p_we_o,
  output logic [3:0]  p_be_o,
  output logic [31:0] p_wdata_o,
  input  logic [31:0] p_rdata_i,
  input  logic        p_ack_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    PER_WAIT = 2'd2,
    ERR_RSP  = 2'd3
  } state_e;

  // Counter value in the last permitted wait cycle; no ack there means timeout.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ram_we_q;     // outstanding RAM access is a write -> respond with 0
  logic [15:0] cnt_q;
  logic [31:0] d_rdata_q;
  logic        d_valid_q, d_err_q;
  logic [15:0] p_addr_q;
  logic        p_req_q, p_we_q;
  logic [3:0]  p_be_q;
  logic [31:0] p_wdata_q;

  // Decode; a malformed access never reaches either target.
  logic bad_acc, ram_hit, per_hit, accept, per_timeout;

  assign bad_acc     = (d_addr_i[1:0] != 2'b00) || (d_be_i == 4'b0000);
  assign ram_hit     = !bad_acc && (d_addr_i[31:15] == RAM_BASE[31:15]);
  assign per_hit     = !bad_acc && !ram_hit && (d_addr_i[31:16] == PERIPH_BASE[31:16]);
  assign accept      = d_gnt_o;
  assign per_timeout = !p_ack_i && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ram_hit)      state_d = RAM_WAIT;
          else if (per_hit) state_d = PER_WAIT;
          else              state_d = ERR_RSP;
        end
      end
      RAM_WAIT: if (ram_valid_i) state_d = IDLE;
      PER_WAIT: if (p_ack_i || per_timeout) state_d = IDLE;
      ERR_RSP:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Combinational outputs: grant and the RAM port, live only in the accept cycle.
  always_comb begin
    d_gnt_o     = (state_q == IDLE) && d_req_i && !reset_i;
    ram_req_o   = d_gnt_o && ram_hit;
    ram_we_o    = ram_req_o && d_we_i;
    ram_be_o    = ram_req_o ? d_be_i : 4'b0000;
    ram_addr_o  = {d_addr_i[14:2], 2'b00};
    ram_wdata_o = d_wdata_i;
  end

  // Response and peripheral request registers.
  // The error response is launched at the accept edge, so it appears one cycle
  // after accept while the FSM sits in ERR_RSP blocking further grants.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ram_we_q  <= 1'b0;
      cnt_q     <= '0;
      d_rdata_q <= '0;
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      p_addr_q  <= '0;
      p_req_q   <= 1'b0;
      p_we_q    <= 1'b0;
      p_be_q    <= '0;
      p_wdata_q <= '0;
    end else begin
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (ram_hit) begin
              ram_we_q <= d_we_i;
            end else if (per_hit) begin
              p_addr_q  <= d_addr_i[15:0];
              p_we_q    <= d_we_i;
              p_be_q    <= d_be_i;
              p_wdata_q <= d_wdata_i;
              p_req_q   <= 1'b1;
              cnt_q     <= '0;
            end else begin
              d_valid_q <= 1'b1;
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
            end
          end
        end
        RAM_WAIT: begin
          if (ram_valid_i) begin
            d_valid_q <= 1'b1;
            d_rdata_q <= ram_we_q ? 32'h0 : ram_rdata_i;
          end
        end
        PER_WAIT: begin
          // An ack in the final wait cycle still counts as normal completion.
          if (p_ack_i) begin
            p_req_q   <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= p_we_q ? 32'h0 : p_rdata_i;
          end else if (per_timeout) begin
            p_req_q   <= 1'b0;
            d_valid_q <= 1'b1;
            d_err_q   <= 1'b1;
            d_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d_rdata_o = d_rdata_q;
  assign d_valid_o = d_valid_q;
  assign d_err_o   = d_err_q;
  assign p_addr_o  = p_addr_q;
  assign p_req_o   = p_req_q;
  assign p_we_o    = p_we_q;
  assign p_be_o    = p_be_q;
  assign p_wdata_o = p_wdata_q;

endmodule
